// File: rtl/fourstate_pkg.sv
// -----------------------------------------------------------------------------
// fourstate_pkg
// Shared constants for the 4-state operator unit: opcodes, FSM state
// encodings and the (aval,bval) symbol encodings 0/1/z/x.
// -----------------------------------------------------------------------------
package fourstate_pkg;

    // Opcodes; 13..15 are undefined and reported as illegal
    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_OR      = 4'd1;
    localparam logic [3:0] OP_XOR     = 4'd2;
    localparam logic [3:0] OP_XNOR    = 4'd3;
    localparam logic [3:0] OP_NOT     = 4'd4;
    localparam logic [3:0] OP_RAND    = 4'd5;
    localparam logic [3:0] OP_ROR     = 4'd6;
    localparam logic [3:0] OP_RXOR    = 4'd7;
    localparam logic [3:0] OP_RXNOR   = 4'd8;
    localparam logic [3:0] OP_SHL     = 4'd9;
    localparam logic [3:0] OP_SHR     = 4'd10;
    localparam logic [3:0] OP_CASE_EQ = 4'd11;
    localparam logic [3:0] OP_LOG_EQ  = 4'd12;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REDUCE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Single-bit symbols as {aval,bval}
    localparam logic [1:0] V0 = 2'b00;
    localparam logic [1:0] V1 = 2'b10;
    localparam logic [1:0] VZ = 2'b01;
    localparam logic [1:0] VX = 2'b11;

endpackage

// File: rtl/fourstate_bit_op.sv
// -----------------------------------------------------------------------------
// fourstate_bit_op
// Combinational single-bit AND/OR/XOR/XNOR/NOT on {aval,bval} symbols.
// Any produced unknown is returned as x.
//   op_sel  in  4  opcode (OP_AND..OP_NOT; anything else yields x)
//   a       in  2  first operand symbol
//   b       in  2  second operand symbol (ignored for NOT)
//   y_c     out 2  result symbol
// -----------------------------------------------------------------------------
module fourstate_bit_op
    import fourstate_pkg::*;
(
    input  logic [3:0] op_sel,
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] y_c
);

    logic unk_c;

    always_comb begin
        unk_c = a[0] | b[0];
        y_c   = VX;
        case (op_sel)
            OP_AND: begin
                if (a == V0 || b == V0) y_c = V0;
                else if (unk_c)         y_c = VX;
                else                    y_c = V1;
            end
            OP_OR: begin
                if (a == V1 || b == V1) y_c = V1;
                else if (unk_c)         y_c = VX;
                else                    y_c = V0;
            end
            OP_XOR:  y_c = unk_c ? VX : {a[1] ^ b[1], 1'b0};
            OP_XNOR: y_c = unk_c ? VX : {~(a[1] ^ b[1]), 1'b0};
            OP_NOT:  y_c = a[0]  ? VX : {~a[1], 1'b0};
            default: y_c = VX;
        endcase
    end

endmodule

// File: rtl/fourstate_seq_alu.sv
// -----------------------------------------------------------------------------
// fourstate_seq_alu
// Iterative 4-state operator unit. Bitwise/equality ops finish in one cycle,
// shifts move one position per cycle, reductions fold one bit per cycle.
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   in_op                         opcode
//   in_a_aval/in_a_bval           operand A planes
//   in_b_aval/in_b_bval           operand B planes (shift amount for shifts)
//   out_valid/out_ready           result handshake
//   out_aval/out_bval             result planes
//   out_op, out_illegal           opcode of result, undefined-opcode flag
// -----------------------------------------------------------------------------
module fourstate_seq_alu
    import fourstate_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [W-1:0] in_a_aval,
    input  logic [W-1:0] in_a_bval,
    input  logic [W-1:0] in_b_aval,
    input  logic [W-1:0] in_b_bval,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_aval,
    output logic [W-1:0] out_bval,
    output logic [3:0]   out_op,
    output logic         out_illegal
);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [W-1:0]  wk_aval_q, wk_aval_d;
    logic [W-1:0]  wk_bval_q, wk_bval_d;
    logic [1:0]    acc_q, acc_d;
    logic [W-1:0]  out_aval_q, out_aval_d;
    logic [W-1:0]  out_bval_q, out_bval_d;
    logic [3:0]    out_op_q, out_op_d;
    logic          out_illegal_q, out_illegal_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [W-1:0]  bw_aval_c, bw_bval_c;
    logic [3:0]    red_sel_c;
    logic [1:0]    red_y_c, inv_y_c;
    logic [CW-1:0] shamt_c;
    logic [W-1:0]  sh_aval_c, sh_bval_c;
    logic          case_eq_c;
    logic [1:0]    log_eq_c;

    // Bitwise datapath on the incoming operands
    for (genvar i = 0; i < W; i++) begin : g_bw
        logic [1:0] y;
        fourstate_bit_op u_bit (
            .op_sel (in_op),
            .a      ({in_a_aval[i], in_a_bval[i]}),
            .b      ({in_b_aval[i], in_b_bval[i]}),
            .y_c    (y)
        );
        assign bw_aval_c[i] = y[1];
        assign bw_bval_c[i] = y[0];
    end

    // Reduction accumulator folds the current LSB of the work register
    fourstate_bit_op u_red (
        .op_sel (red_sel_c),
        .a      (acc_q),
        .b      ({wk_aval_q[0], wk_bval_q[0]}),
        .y_c    (red_y_c)
    );

    // RXNOR is RXOR followed by inversion of the final accumulator
    fourstate_bit_op u_inv (
        .op_sel (OP_NOT),
        .a      (red_y_c),
        .b      (V0),
        .y_c    (inv_y_c)
    );

    // Operator selection, shift amount, one-step shift and equality results
    always_comb begin
        case (op_q)
            OP_RAND: red_sel_c = OP_AND;
            OP_ROR:  red_sel_c = OP_OR;
            default: red_sel_c = OP_XOR;
        endcase

        if (32'(in_b_aval) >= W) shamt_c = CW'(W);
        else                     shamt_c = CW'(in_b_aval);

        if (op_q == OP_SHL) begin
            sh_aval_c = {wk_aval_q[W-2:0], 1'b0};
            sh_bval_c = {wk_bval_q[W-2:0], 1'b0};
        end else begin
            sh_aval_c = {1'b0, wk_aval_q[W-1:1]};
            sh_bval_c = {1'b0, wk_bval_q[W-1:1]};
        end

        case_eq_c = (in_a_aval == in_b_aval) && (in_a_bval == in_b_bval);

        // A known differing bit decides 0 before any unknown can make it x
        if (|((in_a_aval ^ in_b_aval) & ~in_a_bval & ~in_b_bval)) log_eq_c = V0;
        else if (|(in_a_bval | in_b_bval))                        log_eq_c = VX;
        else                                                      log_eq_c = V1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        wk_aval_d     = wk_aval_q;
        wk_bval_d     = wk_bval_q;
        acc_d         = acc_q;
        out_aval_d    = out_aval_q;
        out_bval_d    = out_bval_q;
        out_op_d      = out_op_q;
        out_illegal_d = out_illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d          = in_op;
                    wk_aval_d     = in_a_aval;
                    wk_bval_d     = in_a_bval;
                    out_op_d      = in_op;
                    out_illegal_d = 1'b0;
                    out_aval_d    = '0;
                    out_bval_d    = '0;
                    state_d       = ST_DONE;
                    case (in_op)
                        OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NOT: begin
                            out_aval_d = bw_aval_c;
                            out_bval_d = bw_bval_c;
                        end
                        OP_CASE_EQ: out_aval_d[0] = case_eq_c;
                        OP_LOG_EQ: begin
                            out_aval_d[0] = log_eq_c[1];
                            out_bval_d[0] = log_eq_c[0];
                        end
                        OP_SHL, OP_SHR: begin
                            if (|in_b_bval) begin
                                out_aval_d = '1;
                                out_bval_d = '1;
                            end else if (shamt_c == '0) begin
                                out_aval_d = in_a_aval;
                                out_bval_d = in_a_bval;
                            end else begin
                                cnt_d   = shamt_c;
                                state_d = ST_SHIFT;
                            end
                        end
                        OP_RAND, OP_ROR, OP_RXOR, OP_RXNOR: begin
                            acc_d   = (in_op == OP_RAND) ? V1 : V0;
                            cnt_d   = CW'(W);
                            state_d = ST_REDUCE;
                        end
                        default: begin
                            out_aval_d    = '1;
                            out_bval_d    = '1;
                            out_illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                wk_aval_d = sh_aval_c;
                wk_bval_d = sh_bval_c;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_aval_d = sh_aval_c;
                    out_bval_d = sh_bval_c;
                    state_d    = ST_DONE;
                end
            end
            ST_REDUCE: begin
                acc_d     = red_y_c;
                wk_aval_d = wk_aval_q >> 1;
                wk_bval_d = wk_bval_q >> 1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_aval_d    = '0;
                    out_bval_d    = '0;
                    out_aval_d[0] = (op_q == OP_RXNOR) ? inv_y_c[1] : red_y_c[1];
                    out_bval_d[0] = (op_q == OP_RXNOR) ? inv_y_c[0] : red_y_c[0];
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            wk_aval_q     <= '0;
            wk_bval_q     <= '0;
            acc_q         <= V0;
            out_aval_q    <= '0;
            out_bval_q    <= '0;
            out_op_q      <= '0;
            out_illegal_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            wk_aval_q     <= wk_aval_d;
            wk_bval_q     <= wk_bval_d;
            acc_q         <= acc_d;
            out_aval_q    <= out_aval_d;
            out_bval_q    <= out_bval_d;
            out_op_q      <= out_op_d;
            out_illegal_q <= out_illegal_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_aval    = out_aval_q;
    assign out_bval    = out_bval_q;
    assign out_op      = out_op_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_fourstate_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_fourstate_seq_alu
// Directed vector table, hand-written backpressure and reset sequences, and
// random requests checked against a symbol-level reference model.
// Operands are written as 4-character strings of 0/1/z/x (MSB first) and
// packed as {aval[3:0], bval[3:0]}.
// -----------------------------------------------------------------------------
module tb_fourstate_seq_alu;

    localparam int W = 4;
    localparam logic [1:0] S0 = 2'b00, S1 = 2'b10, SX = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a_aval, in_a_bval, in_b_aval, in_b_bval;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_aval, out_bval;
    logic [3:0]   out_op;
    logic         out_illegal;

    int errors = 0;
    int checks = 0;

    fourstate_seq_alu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a_aval   (in_a_aval),
        .in_a_bval   (in_a_bval),
        .in_b_aval   (in_b_aval),
        .in_b_bval   (in_b_bval),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_aval    (out_aval),
        .out_bval    (out_bval),
        .out_op      (out_op),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        int         lat;
        logic       ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] p4(input string s);
        logic [3:0] av, bv;
        byte c;
        av = '0;
        bv = '0;
        for (int i = 0; i < 4; i++) begin
            c = s[i];
            if (c == "1" || c == "x") av[3-i] = 1'b1;
            if (c == "z" || c == "x") bv[3-i] = 1'b1;
        end
        return {av, bv};
    endfunction

    function automatic logic [1:0] sym(input logic [7:0] p, input int i);
        return {p[4+i], p[i]};
    endfunction

    // kind: 0 and, 1 or, 2 xor, 3 xnor, 4 not
    function automatic logic [1:0] mbit(input int kind, input logic [1:0] s, input logic [1:0] t);
        logic su, tu, sv, tv;
        su = s[0]; tu = t[0]; sv = s[1]; tv = t[1];
        case (kind)
            0: begin
                if ((!su && !sv) || (!tu && !tv)) return S0;
                if (su || tu) return SX;
                return S1;
            end
            1: begin
                if ((!su && sv) || (!tu && tv)) return S1;
                if (su || tu) return SX;
                return S0;
            end
            2: return (su || tu) ? SX : ((sv != tv) ? S1 : S0);
            3: return (su || tu) ? SX : ((sv == tv) ? S1 : S0);
            4: return su ? SX : (sv ? S0 : S1);
            default: return SX;
        endcase
    endfunction

    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output int lat, output logic ill);
        logic [3:0] ra, rb;
        logic [1:0] y, acc;
        int o, k;
        logic diff, unk;
        ra = '0; rb = '0; lat = 1; ill = 1'b0;
        o = int'(op);
        if (o <= 4) begin
            for (int i = 0; i < W; i++) begin
                y = mbit(o, sym(a, i), sym(b, i));
                ra[i] = y[1];
                rb[i] = y[0];
            end
        end else if (o <= 8) begin
            acc = (o == 5) ? S1 : S0;
            for (int i = 0; i < W; i++)
                acc = mbit((o == 5) ? 0 : (o == 6) ? 1 : 2, acc, sym(a, i));
            if (o == 8) acc = mbit(4, acc, S0);
            ra[0] = acc[1];
            rb[0] = acc[0];
            lat = 1 + W;
        end else if (o <= 10) begin
            if (b[3:0] != 4'b0) begin
                ra = '1; rb = '1;
            end else begin
                k = int'(b[7:4]);
                if (k < W) begin
                    ra = (o == 9) ? (a[7:4] << k) : (a[7:4] >> k);
                    rb = (o == 9) ? (a[3:0] << k) : (a[3:0] >> k);
                end
                lat = 1 + ((k < W) ? k : W);
            end
        end else if (o == 11) begin
            ra[0] = (a == b);
        end else if (o == 12) begin
            diff = 1'b0; unk = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (!a[i] && !b[i] && (a[4+i] != b[4+i])) diff = 1'b1;
                if (a[i] || b[i]) unk = 1'b1;
            end
            y = diff ? S0 : (unk ? SX : S1);
            ra[0] = y[1];
            rb[0] = y[0];
        end else begin
            ra = '1; rb = '1; ill = 1'b1;
        end
        r = {ra, rb};
    endfunction

    // Issue one request and wait (bounded) for its result; leaves out_ready low
    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output int lat, output logic ill, output logic [3:0] oop);
        int g;
        g = 0;
        while (!in_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op = op;
        in_a_aval = a[7:4]; in_a_bval = a[3:0];
        in_b_aval = b[7:4]; in_b_bval = b[3:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("valid_wait", 32'(out_valid), 32'd1);
        res = {out_aval, out_bval};
        ill = out_illegal;
        oop = out_op;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] res, ea, eb, er;
        logic [3:0] oop, op;
        logic ill, eill, seen;
        int lat, elat, hold;

        vecs[0]  = '{4'd0,  p4("1001"), p4("x001"), p4("x001"), 1, 1'b0};
        vecs[1]  = '{4'd1,  p4("0001"), p4("z001"), p4("x001"), 1, 1'b0};
        vecs[2]  = '{4'd2,  p4("1z10"), p4("0110"), p4("1x00"), 1, 1'b0};
        vecs[3]  = '{4'd3,  p4("0110"), p4("0101"), p4("1100"), 1, 1'b0};
        vecs[4]  = '{4'd4,  p4("01zx"), p4("1111"), p4("10xx"), 1, 1'b0};
        vecs[5]  = '{4'd9,  p4("10z1"), p4("0001"), p4("0z10"), 2, 1'b0};
        vecs[6]  = '{4'd10, p4("10x1"), p4("0001"), p4("010x"), 2, 1'b0};
        vecs[7]  = '{4'd9,  p4("1111"), p4("0111"), p4("0000"), 5, 1'b0};
        vecs[8]  = '{4'd10, p4("1z11"), p4("0100"), p4("0000"), 5, 1'b0};
        vecs[9]  = '{4'd10, p4("z1x0"), p4("0000"), p4("z1x0"), 1, 1'b0};
        vecs[10] = '{4'd5,  p4("x111"), p4("0000"), p4("000x"), 5, 1'b0};
        vecs[11] = '{4'd6,  p4("1001"), p4("0000"), p4("0001"), 5, 1'b0};
        vecs[12] = '{4'd7,  p4("z001"), p4("0000"), p4("000x"), 5, 1'b0};
        vecs[13] = '{4'd8,  p4("1001"), p4("0000"), p4("0001"), 5, 1'b0};
        vecs[14] = '{4'd11, p4("x001"), p4("x001"), p4("0001"), 1, 1'b0};
        vecs[15] = '{4'd11, p4("x0x1"), p4("x001"), p4("0000"), 1, 1'b0};
        vecs[16] = '{4'd12, p4("0101"), p4("0101"), p4("0001"), 1, 1'b0};
        vecs[17] = '{4'd12, p4("1x00"), p4("0x00"), p4("0000"), 1, 1'b0};
        vecs[18] = '{4'd9,  p4("1011"), p4("00x1"), p4("xxxx"), 1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0;
        in_a_aval = '0; in_a_bval = '0; in_b_aval = '0; in_b_bval = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_planes", 32'({out_aval, out_bval}), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            run(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, ill, oop);
            chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_op", i), 32'(oop), 32'(vecs[i].op));
            ack();
        end

        // Undefined opcode
        run(4'd14, p4("0101"), p4("0011"), res, lat, ill, oop);
        chk("illegal_result", 32'(res), 32'hFF);
        chk("illegal_flag", 32'(ill), 32'd1);
        chk("illegal_latency", 32'(lat), 32'd1);
        ack();

        // Backpressure: result held and no new request taken
        run(4'd0, p4("1001"), p4("x001"), res, lat, ill, oop);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_result", c), 32'({out_aval, out_bval}), 32'(p4("x001")));
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        ack();

        // Reset in the second cycle of a reduction discards it
        in_valid = 1'b1; in_op = 4'd5;
        in_a_aval = 4'hF; in_a_bval = 4'h0; in_b_aval = '0; in_b_bval = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run(4'd0, p4("1100"), p4("1010"), res, lat, ill, oop);
        chk("midrst_and_result", 32'(res), 32'(p4("1000")));
        chk("midrst_and_latency", 32'(lat), 32'd1);
        ack();

        // Random requests against the reference model
        for (int t = 0; t < 150; t++) begin
            op = 4'($urandom_range(0, 15));
            ea = 8'($urandom);
            eb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) ea[3:0] = '0;
            if ($urandom_range(0, 1) == 1) eb[3:0] = '0;
            model(op, ea, eb, er, elat, eill);
            run(op, ea, eb, res, lat, ill, oop);
            chk($sformatf("rnd%0d_op%0d_result", t, op), 32'(res), 32'(er));
            chk($sformatf("rnd%0d_op%0d_latency", t, op), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_op%0d_illegal", t, op), 32'(ill), 32'(eill));
            chk($sformatf("rnd%0d_op%0d_opcode", t, op), 32'(oop), 32'(op));
            hold = $urandom_range(0, 2);
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                chk($sformatf("rnd%0d_hold_valid", t), 32'(out_valid), 32'd1);
                chk($sformatf("rnd%0d_hold_result", t), 32'({out_aval, out_bval}), 32'(er));
            end
            ack();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fourstate_seq_alu.md
Name: fourstate_seq_alu

Overview:
- Iterative 4-state operator unit: computes Verilog bitwise, reduction, shift and equality operators on x/z-carrying operands.
- Upstream stage of the operator result checker: results are presented with a valid/ready handshake for comparison against expected 4-state constants.
- Shifts and reductions are bit-serial, so latency depends on the operation.

Parameters:
- W, 4, operand and result width in bits (W >= 2).
- CW, $clog2(W+1), iteration counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  4  opcode, encodings given under Decomposition.
- in_a_aval  in  W  operand A value plane.
- in_a_bval  in  W  operand A unknown plane.
- in_b_aval  in  W  operand B value plane; also the shift amount.
- in_b_bval  in  W  operand B unknown plane.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_aval  out  W  result value plane.
- out_bval  out  W  result unknown plane.
- out_op  out  4  opcode of the result.
- out_illegal  out  1  result came from an undefined opcode.

Behaviour:
- Bit encoding (aval,bval): 0=(0,0), 1=(1,0), z=(0,1), x=(1,1).
- All results are normalised: any produced unknown bit is x, except that shifts preserve z.
- Reset: state IDLE, counter 0. Outputs: out_valid=0, in_ready=1, out_aval=0, out_bval=0, out_op=0, out_illegal=0.
- Reset during SHIFT, REDUCE or DONE discards the transaction; no result is emitted.
- States: IDLE, SHIFT, REDUCE, DONE.
- in_ready=1 only in IDLE. Accept occurs when in_valid & in_ready; operands and opcode are captured into internal registers.

Operations and timing (request accepted in cycle n):
- AND, OR, XOR, XNOR, NOT, CASE_EQ, LOG_EQ, illegal: IDLE->DONE; out_valid in cycle n+1.
  - AND: 0 dominates, else any unknown -> x.
  - OR: 1 dominates, else any unknown -> x.
  - XOR, XNOR, NOT: any unknown input bit -> x.
  - CASE_EQ: result[0] = 1 iff both planes match exactly; otherwise 0. Never x.
  - LOG_EQ: result[0] = 0 if any bit pair is known and differs; else x if any bit is unknown; else 1.
  - Illegal opcode: out_aval = out_bval = all ones (all x); out_illegal=1.
- SHL, SHR: shift amount k = B.
  - If B contains any unknown bit: result all x, IDLE->DONE, no iteration.
  - Otherwise the counter loads min(k,W) and the state goes to SHIFT. Each cycle shifts both planes by one position, fill (0,0), and decrements the counter. At 0 the state goes to DONE.
  - out_valid in cycle n+1+min(k,W); k=0 goes directly to DONE.
  - k >= W yields all 0.
- RAND, ROR, RXOR, RXNOR: REDUCE consumes one bit per cycle, LSB first, for exactly W cycles; out_valid in cycle n+1+W.
  - Accumulators follow the dominance rules above. An x accumulator remains x for XOR.
  - Result is in bit 0; bits [W-1:1] are (0,0).
- DONE: holds all outputs stable while out_valid & !out_ready.
  - On handshake, go to IDLE; out_valid drops the next cycle.
  - Maximum throughput is one request per 2 cycles.
- The B operand is ignored for NOT and reductions.

Decomposition:
- Package fourstate_pkg:
  - opcode constants: AND=0, OR=1, XOR=2, XNOR=3, NOT=4, RAND=5, ROR=6, RXOR=7, RXNOR=8, SHL=9, SHR=10, CASE_EQ=11, LOG_EQ=12; 13-15 illegal.
  - state enum.
  - constants V0, V1, VX, VZ (2-bit aval/bval).
- One sub-module, fourstate_bit_op: a combinational single-bit AND/OR/XOR/XNOR/NOT on (aval,bval) pairs. It is shared by the bitwise datapath (W instances) and the reduction accumulator.

Test Plan:
- AND A=4'b1001, B=4'bx001 -> 1 cycle, result 4'bx001. OR A=4'b0001, B=4'bz001 -> 4'bx001.
- SHL A=4'b10z1, B=1 -> out_valid at n+2, result 4'b0z10. SHR A=4'b10x1, B=1 -> 4'b010x. SHL B=7 -> 4'b0000 at n+1+4.
- RAND A=4'bx111 -> result[0]=x at n+5. ROR A=4'b1001 -> 1. RXOR A=4'bz001 -> x. RXNOR A=4'b1001 -> 1.
- CASE_EQ A=4'bx001, B=4'bx001 -> 1. CASE_EQ A=4'bx0x1, B=4'bx001 -> 0. LOG_EQ A=5, B=5 -> 1. LOG_EQ A=4'b1x00, B=4'b0x00 -> 0.
- Backpressure: hold out_ready=0 for 3 cycles after DONE -> outputs stable and in_ready=0 throughout. SHL with B=4'b00x1 -> all x, 1-cycle latency. Opcode 14 -> out_illegal=1, result all x.
- Assert rst in the 2nd cycle of a RAND -> next cycle IDLE, in_ready=1, out_valid=0; a new AND then completes normally.
